// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: PC redirect and stall controls, instruction memory port,
// and the decode-facing valid/ready stream.
interface fetch_sequencer_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_err;

  modport master (
    output fetch_en, redirect_valid, redirect_pc, imem_instr, out_ready,
    input  imem_pc, out_valid, out_pc, out_instr, fetch_err
  );

  modport slave (
    input  fetch_en, redirect_valid, redirect_pc, imem_instr, out_ready,
    output imem_pc, out_valid, out_pc, out_instr, fetch_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the fetch PC, fills a small prefetch FIFO
// from a combinational-read memory and halts on a bad fetch address.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 64,
  parameter int          DEPTH     = 2
) (
  input logic              clk,
  input logic              reset_n,
  fetch_sequencer_if.slave bus
);
  localparam int              AW         = $clog2(DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [31:0]     LAST_PC    = 32'(MEM_BYTES - 4);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fpc_reg, fpc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic          err_reg, err_next;
  logic          push, pop, valid, fpc_legal;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  // The range check also catches the wrap of fpc + 4 past 2^32.
  assign fpc_legal = (fpc_reg[1:0] == 2'b00) && (fpc_reg <= LAST_PC);
  assign valid     = (count_reg != '0);

  always_comb begin
    state_next  = state_reg;
    fpc_next    = fpc_reg;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    err_next    = err_reg;
    push        = 1'b0;
    pop         = valid && bus.out_ready;

    if (state_reg == RUN && bus.redirect_valid) begin
      // Redirect wins over everything: a concurrent pop is dropped with the flush.
      pop         = 1'b0;
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      fpc_next    = bus.redirect_pc;
    end else begin
      if (state_reg == RUN && !fpc_legal) begin
        state_next = HALT;
        err_next   = 1'b1;
      end
      push = (state_reg == RUN) && bus.fetch_en && fpc_legal &&
             ((count_reg < FULL_COUNT) || pop);
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
        fpc_next    = fpc_reg + 32'd4;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= RUN;
      fpc_reg    <= RESET_PC;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      fpc_reg    <= fpc_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      err_reg    <= err_next;
    end
  end

  // Entry storage needs no reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      pc_mem[wr_ptr_reg]    <= fpc_reg;
      instr_mem[wr_ptr_reg] <= bus.imem_instr;
    end
  end

  assign bus.imem_pc   = fpc_reg;
  assign bus.out_valid = valid;
  assign bus.out_pc    = valid ? pc_mem[rd_ptr_reg]    : 32'd0;
  assign bus.out_instr = valid ? instr_mem[rd_ptr_reg] : 32'd0;
  assign bus.fetch_err = err_reg;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard queue of expected PCs
// popped on every accepted decode handshake.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic exp_halt = 1'b0;
  logic [31:0] exp_q [$];

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (64),
    .DEPTH     (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    if (pc < 32'd64) return 32'h0000_0013 + (pc >> 2) * 32'h0010_0080;
    return 32'hDEAD_BEEF;
  endfunction

  assign bus.imem_instr = mem_word(bus.imem_pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_pcs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  // A handshake counts unless a redirect flushes it while still running.
  task automatic tick();
    logic [31:0] e;
    if (bus.out_valid && bus.out_ready && !(bus.redirect_valid && !exp_halt)) begin
      chk("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_out_pc", bus.out_pc, e);
        chk("sb_out_instr", bus.out_instr, mem_word(e));
        $display("accept pc=%h instr=%h", bus.out_pc, bus.out_instr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n            = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    exp_q.delete();
    exp_halt = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_fetch_err", {31'd0, bus.fetch_err}, 32'd0);
    chk("rst_imem_pc", bus.imem_pc, 32'd0);

    // Streaming from reset
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b1;
    expect_pcs(32'h0, 3);
    tick();
    chk("first_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("first_pc", bus.out_pc, 32'h0);
    repeat (3) tick();
    bus.out_ready = 1'b0;
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure fill, then resume
    do_reset();
    bus.fetch_en  = 1'b1;
    expect_pcs(32'h0, 5);
    repeat (5) tick();
    chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("stall_imem_pc", bus.imem_pc, 32'h8);
    chk("stall_head_pc", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    chk("resume_drained", 32'(exp_q.size()), 32'd0);

    // Redirect while full
    expect_pcs(32'h20, 3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("redir_imem_pc", bus.imem_pc, 32'h20);
    tick();
    chk("redir_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("redir_out_pc", bus.out_pc, 32'h20);
    repeat (3) tick();
    chk("redir_drained", 32'(exp_q.size()), 32'd0);

    // Redirect to a misaligned address
    exp_q.delete();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h22;
    tick();
    bus.redirect_valid = 1'b0;
    chk("misalign_loaded", bus.imem_pc, 32'h22);
    chk("misalign_err_early", {31'd0, bus.fetch_err}, 32'd0);
    tick();
    exp_halt = 1'b1;
    chk("misalign_err", {31'd0, bus.fetch_err}, 32'd1);
    chk("misalign_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    chk("halt_ignores_redirect", bus.imem_pc, 32'h22);
    chk("halt_no_push", {31'd0, bus.out_valid}, 32'd0);
    chk("halt_err_sticky", {31'd0, bus.fetch_err}, 32'd1);

    // Run off the end of memory
    do_reset();
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b1;
    expect_pcs(32'h0, 16);
    repeat (16) tick();
    chk("end_head_pc", bus.out_pc, 32'h3C);
    chk("end_err_before", {31'd0, bus.fetch_err}, 32'd0);
    bus.out_ready = 1'b0;
    tick();
    exp_halt = 1'b1;
    chk("end_err", {31'd0, bus.fetch_err}, 32'd1);
    chk("end_still_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("end_still_pc", bus.out_pc, 32'h3C);
    bus.out_ready = 1'b1;
    tick();
    chk("end_drained_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("end_drained_q", 32'(exp_q.size()), 32'd0);
    chk("end_fpc_frozen", bus.imem_pc, 32'h40);

    // Reset while halted with a full FIFO
    do_reset();
    bus.fetch_en       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h38;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (3) tick();
    chk("pre_rst_err", {31'd0, bus.fetch_err}, 32'd1);
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("pre_rst_pc", bus.out_pc, 32'h38);
    chk("pre_rst_fpc", bus.imem_pc, 32'h40);
    reset_n = 1'b0;
    tick();
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_pc", bus.out_pc, 32'd0);
    chk("midrst_instr", bus.out_instr, 32'd0);
    chk("midrst_err", {31'd0, bus.fetch_err}, 32'd0);
    chk("midrst_fpc", bus.imem_pc, 32'd0);
    reset_n       = 1'b1;
    exp_halt      = 1'b0;
    bus.out_ready = 1'b1;
    expect_pcs(32'h0, 2);
    tick();
    chk("restart_pc", bus.out_pc, 32'h0);
    repeat (2) tick();
    chk("restart_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller sitting between the program counter logic and the byte-addressed, combinational-read `instruction_memory`. It owns the fetch PC, drives the memory address, captures each 32-bit instruction into a small prefetch FIFO, and presents `{pc, instr}` pairs to decode over a valid/ready handshake. It handles stalls (decode back-pressure, `fetch_en` low), redirects (branch/jump) with FIFO flush, and halts permanently on a misaligned or out-of-range fetch address.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset; must be 4-byte aligned.
- `MEM_BYTES`, 64: instruction memory size in bytes; legal fetch PCs are `0 .. MEM_BYTES-4`.
- `DEPTH`, 2: prefetch FIFO entries; power of two, >= 2.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `fetch_en` in 1: enables new fetches; low stalls fetch without disturbing FIFO contents.
- `redirect_valid` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new fetch address.
- `imem_pc` out 32: byte address to `instruction_memory`; equals current fetch PC.
- `imem_instr` in 32: combinational read data for `imem_pc`, valid in the same cycle.
- `out_valid` out 1: FIFO head holds an instruction.
- `out_ready` in 1: decode accepts head when `out_valid && out_ready`.
- `out_pc` out 32: PC of head instruction; 0 when `out_valid` low.
- `out_instr` out 32: head instruction; 0 when `out_valid` low.
- `fetch_err` out 1: sticky error flag; set on bad fetch address.

## Operation
- States: RUN, HALT. Reset -> RUN. RUN -> HALT when the fetch PC about to be used is misaligned (`pc[1:0] != 0`) or `pc > MEM_BYTES-4`. HALT exits only via reset.
- Fetch PC register `fpc`; `imem_pc = fpc` at all times.
- Push condition (RUN only): `fetch_en && !redirect_valid && fpc legal && (count < DEPTH || pop)`. On push: enqueue `{fpc, imem_instr}`, `fpc <= fpc + 4`.
- Pop: `out_valid && out_ready`; dequeue head.
- Push and pop in same cycle: both occur; count unchanged. Full FIFO with pop accepts push.
- Redirect (RUN, `redirect_valid=1`): FIFO flushed (count <= 0, any pop that cycle is discarded, no push), `fpc <= redirect_pc`. Redirect has priority over push and pop. `redirect_valid` with `fetch_en=0` still flushes and loads `fpc`.
- Illegal `fpc` in RUN: no push, `fetch_err <= 1`, state <= HALT. Checked on `fpc` only, so an illegal `redirect_pc` is flagged the cycle after it is loaded.
- HALT: no pushes, redirects ignored, FIFO continues to drain normally via handshake, `fpc` frozen, `fetch_err` stays 1.
- `fpc + 4` wraps modulo 2^32; the range check catches it before any push.

## Timing
- Reset (`reset_n=0` at an edge): `fpc=RESET_PC`, count=0, state=RUN, `out_valid=0`, `out_pc=0`, `out_instr=0`, `fetch_err=0`. Reset mid-stream discards FIFO contents and any pending error.
- First cycle after reset with `fetch_en=1`: push at end of that cycle; `out_valid=1`, `out_pc=RESET_PC` the next cycle.
- Redirect asserted in cycle N: cycle N+1 `imem_pc=redirect_pc`, `out_valid=0`; cycle N+2 `out_valid=1`, `out_pc=redirect_pc`. Redirect-to-output latency 2 cycles.
- Steady state with `out_ready=1`, `fetch_en=1`: one instruction per cycle, consecutive PCs +4.
- `out_ready=0`: FIFO fills to DEPTH, then `fpc` holds; no instruction lost or duplicated on resume.
- Outputs `out_*` are registered FIFO head values; no combinational path from `imem_instr` or `redirect_*` to `out_*`.

## Test plan
- Reset release, `fetch_en=1`, `out_ready=1`, memory words 0x00000013, 0x00100093, ... -> `out_pc` 0x0,0x4,0x8 on consecutive cycles starting one cycle after reset release, `out_instr` matching memory.
- Hold `out_ready=0` 5 cycles then 1 -> `out_valid` stays 1, `imem_pc` stops at RESET_PC+4*DEPTH, resumed stream 0x0,0x4,0x8,... with no gaps or repeats.
- Redirect to 0x20 while FIFO full -> next cycle `out_valid=0`, following cycle `out_pc=0x20`; pre-redirect entries never appear.
- Redirect to 0x22 -> one cycle later `fetch_err=1`, no further pushes, FIFO already flushed so `out_valid=0`; later redirect to 0x10 ignored until reset.
- Sequential fetch reaching 0x3C with `MEM_BYTES=64` -> 0x3C delivered, then `fpc=0x40` sets `fetch_err=1`, HALT, remaining entries still drain.
- Assert `reset_n=0` mid-stream with `fetch_err=1` and FIFO full -> next cycle all outputs zero, `fetch_err=0`, fetch restarts at RESET_PC.
